lc3_ctrl_fsm: RTL and testbench

LC3_CTRL_FSM -- requirements
Module: lc3_ctrl_fsm

---
 rtl/lc3_ctrl_fsm_if.sv | 50 +++++
 rtl/lc3_ctrl_fsm.sv | 194 +++++++++++++++++++
 tb/tb_lc3_ctrl_fsm.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_ctrl_fsm_if.sv
// Control bundle between the LC-3 control FSM and the datapath/memory side.
// The master side is the control FSM; the slave side is the datapath that
// supplies status and consumes the load/gate/mux controls.
interface lc3_ctrl_fsm_if;
   // status into the controller
   logic        Run;
   logic        Continue;
   logic [15:0] IR;
   logic        BEN;
   logic        Mem_RDY;
   // load enables
   logic        LD_MAR;
   logic        LD_MDR;
   logic        LD_IR;
   logic        LD_LOGIC;
   logic        LD_CC;
   logic        LD_REG;
   logic        LD_PC;
   // bus gates
   logic        GatePC;
   logic        GateMDR;
   logic        GateALU;
   logic        GateMARMUX;
   // memory handshake
   logic        Mem_REQ;
   logic        Mem_WE;
   // mux selects
   logic        SR1MUX;
   logic        DRMUX;
   logic        ADDR1MUX;
   logic [1:0]  PCMUX;
   logic [1:0]  ADDR2MUX;
   logic [1:0]  ALUK;
   // debug view of the state register
   logic [4:0]  State;

   modport master (
      input  Run, Continue, IR, BEN, Mem_RDY,
      output LD_MAR, LD_MDR, LD_IR, LD_LOGIC, LD_CC, LD_REG, LD_PC,
             GatePC, GateMDR, GateALU, GateMARMUX, Mem_REQ, Mem_WE,
             SR1MUX, DRMUX, ADDR1MUX, PCMUX, ADDR2MUX, ALUK, State
   );

   modport slave (
      output Run, Continue, IR, BEN, Mem_RDY,
      input  LD_MAR, LD_MDR, LD_IR, LD_LOGIC, LD_CC, LD_REG, LD_PC,
             GatePC, GateMDR, GateALU, GateMARMUX, Mem_REQ, Mem_WE,
             SR1MUX, DRMUX, ADDR1MUX, PCMUX, ADDR2MUX, ALUK, State
   );
endinterface

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 subset control FSM: fetch/decode/execute for ADD/AND/NOT, BR, JMP,
// LDR, STR and a PAUSE trap. State encoding follows the declaration order
// below (HALTED = 0) and is exported on State for debug.
// All outputs decode the state register; the only input that reaches an
// output combinationally is Mem_RDY (LD_MDR in the read-wait states). The
// ALU operation of ALU-class instructions is captured at DECODE so that IR
// never feeds ALUK directly.
module lc3_ctrl_fsm (
   input  logic                 Clk,
   input  logic                 Reset_n,
   lc3_ctrl_fsm_if.master       bus
);

   typedef enum logic [4:0] {
      HALTED = 5'd0,
      F1     = 5'd1,
      F2     = 5'd2,
      F3     = 5'd3,
      DECODE = 5'd4,
      ALU    = 5'd5,
      BR     = 5'd6,
      BR_T   = 5'd7,
      JMP    = 5'd8,
      LDR1   = 5'd9,
      LDR2   = 5'd10,
      LDR3   = 5'd11,
      STR1   = 5'd12,
      STR2   = 5'd13,
      STR3   = 5'd14,
      PAUSE1 = 5'd15,
      PAUSE2 = 5'd16
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  aluk_q, aluk_d;
   logic [3:0]  opcode_s;

   assign opcode_s = bus.IR[15:12];

   // State and latched ALU operation registers; reset forces HALTED at once.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= HALTED;
         aluk_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         aluk_q  <= aluk_d;
      end
   end

   // Next-state selection and ALU-operation capture at DECODE.
   always_comb begin
      state_d = state_q;
      aluk_d  = aluk_q;
      case (state_q)
         HALTED: begin
            if (bus.Run) state_d = F1;
            else         state_d = HALTED;
         end
         F1: state_d = F2;
         F2: begin
            if (bus.Mem_RDY) state_d = F3;
            else             state_d = F2;
         end
         F3: state_d = DECODE;
         DECODE: begin
            if (opcode_s == 4'b0101)      aluk_d = 2'b01;
            else if (opcode_s == 4'b1001) aluk_d = 2'b10;
            else                          aluk_d = 2'b00;
            case (opcode_s)
               4'b0001, 4'b0101, 4'b1001: state_d = ALU;
               4'b0000:                   state_d = BR;
               4'b1100:                   state_d = JMP;
               4'b0110:                   state_d = LDR1;
               4'b0111:                   state_d = STR1;
               4'b1101:                   state_d = PAUSE1;
               default:                   state_d = F1;
            endcase
         end
         ALU: state_d = F1;
         BR: begin
            if (bus.BEN) state_d = BR_T;
            else         state_d = F1;
         end
         BR_T: state_d = F1;
         JMP:  state_d = F1;
         LDR1: state_d = LDR2;
         LDR2: begin
            if (bus.Mem_RDY) state_d = LDR3;
            else             state_d = LDR2;
         end
         LDR3: state_d = F1;
         STR1: state_d = STR2;
         STR2: state_d = STR3;
         STR3: begin
            if (bus.Mem_RDY) state_d = F1;
            else             state_d = STR3;
         end
         PAUSE1: begin
            if (bus.Continue) state_d = PAUSE2;
            else              state_d = PAUSE1;
         end
         PAUSE2: begin
            if (bus.Continue) state_d = PAUSE2;
            else              state_d = F1;
         end
         // unused encodings park the machine safely
         default: state_d = HALTED;
      endcase
   end

   // Control decode of the current state; at most one bus gate per state.
   always_comb begin
      bus.LD_MAR     = 1'b0;
      bus.LD_MDR     = 1'b0;
      bus.LD_IR      = 1'b0;
      bus.LD_LOGIC   = 1'b0;
      bus.LD_CC      = 1'b0;
      bus.LD_REG     = 1'b0;
      bus.LD_PC      = 1'b0;
      bus.GatePC     = 1'b0;
      bus.GateMDR    = 1'b0;
      bus.GateALU    = 1'b0;
      bus.GateMARMUX = 1'b0;
      bus.Mem_REQ    = 1'b0;
      bus.Mem_WE     = 1'b0;
      bus.SR1MUX     = 1'b0;
      bus.DRMUX      = 1'b0;
      bus.ADDR1MUX   = 1'b0;
      bus.PCMUX      = 2'b00;
      bus.ADDR2MUX   = 2'b00;
      bus.ALUK       = 2'b00;
      bus.State      = state_q;
      case (state_q)
         F1: begin
            bus.GatePC = 1'b1;
            bus.LD_MAR = 1'b1;
            bus.LD_PC  = 1'b1;
            bus.PCMUX  = 2'b00;
         end
         F2, LDR2: begin
            bus.Mem_REQ = 1'b1;
            bus.LD_MDR  = bus.Mem_RDY;
         end
         F3: begin
            bus.GateMDR = 1'b1;
            bus.LD_IR   = 1'b1;
         end
         DECODE: bus.LD_LOGIC = 1'b1;
         ALU: begin
            bus.GateALU = 1'b1;
            bus.LD_REG  = 1'b1;
            bus.LD_CC   = 1'b1;
            bus.SR1MUX  = 1'b1;
            bus.ALUK    = aluk_q;
         end
         BR_T: begin
            bus.LD_PC    = 1'b1;
            bus.PCMUX    = 2'b10;
            bus.ADDR2MUX = 2'b10;
         end
         JMP: begin
            bus.LD_PC    = 1'b1;
            bus.PCMUX    = 2'b10;
            bus.ADDR1MUX = 1'b1;
            bus.SR1MUX   = 1'b1;
         end
         LDR1, STR1: begin
            bus.GateMARMUX = 1'b1;
            bus.LD_MAR     = 1'b1;
            bus.ADDR1MUX   = 1'b1;
            bus.ADDR2MUX   = 2'b01;
            bus.SR1MUX     = 1'b1;
         end
         LDR3: begin
            bus.GateMDR = 1'b1;
            bus.LD_REG  = 1'b1;
            bus.LD_CC   = 1'b1;
         end
         STR2: begin
            bus.GateALU = 1'b1;
            bus.ALUK    = 2'b11;
            bus.LD_MDR  = 1'b1;
         end
         STR3: begin
            bus.Mem_REQ = 1'b1;
            bus.Mem_WE  = 1'b1;
         end
         // HALTED, BR, PAUSE1, PAUSE2 and unused codes drive nothing
         default: bus.State = state_q;
      endcase
   end

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Directed bench for lc3_ctrl_fsm. Inputs change on the falling edge, outputs
// are sampled 1 time unit later, so every sample shows the state entered at the
// preceding rising edge. Expected states/controls are hand-written constants.
module tb_lc3_ctrl_fsm;

   logic Clk = 1'b0;
   logic Reset_n;
   int   checks = 0;
   int   failures = 0;

   lc3_ctrl_fsm_if bus ();

   lc3_ctrl_fsm dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

   always #5 Clk = ~Clk;

   // state codes
   localparam logic [4:0] S_HALT = 5'd0,  S_F1 = 5'd1,  S_F2 = 5'd2,  S_F3 = 5'd3,
                          S_DEC  = 5'd4,  S_ALU = 5'd5, S_BR = 5'd6,  S_BRT = 5'd7,
                          S_JMP  = 5'd8,  S_LDR1 = 5'd9, S_LDR2 = 5'd10, S_LDR3 = 5'd11,
                          S_STR1 = 5'd12, S_STR2 = 5'd13, S_STR3 = 5'd14,
                          S_P1   = 5'd15, S_P2 = 5'd16;

   // control vector bit masks (order of outs() below)
   localparam logic [21:0] M_LD_MAR = 22'h200000, M_LD_MDR = 22'h100000,
                           M_LD_IR  = 22'h080000, M_LD_LOGIC = 22'h040000,
                           M_LD_CC  = 22'h020000, M_LD_REG = 22'h010000,
                           M_LD_PC  = 22'h008000, M_GPC = 22'h004000,
                           M_GMDR   = 22'h002000, M_GALU = 22'h001000,
                           M_GMARMX = 22'h000800, M_MREQ = 22'h000400,
                           M_MWE    = 22'h000200, M_SR1 = 22'h000100,
                           M_DR     = 22'h000080, M_A1 = 22'h000040,
                           M_PC_ADD = 22'h000020, M_A2_OFF6 = 22'h000004,
                           M_A2_OFF9 = 22'h000008, M_K_AND = 22'h000001,
                           M_K_NOT  = 22'h000002, M_K_PASS = 22'h000003;

   localparam logic [21:0] E_HALT   = 22'h000000;
   localparam logic [21:0] E_F1     = M_LD_MAR | M_LD_PC | M_GPC;
   localparam logic [21:0] E_F2W    = M_MREQ;
   localparam logic [21:0] E_F2R    = M_MREQ | M_LD_MDR;
   localparam logic [21:0] E_F3     = M_GMDR | M_LD_IR;
   localparam logic [21:0] E_DEC    = M_LD_LOGIC;
   localparam logic [21:0] E_ADD    = M_GALU | M_LD_REG | M_LD_CC | M_SR1;
   localparam logic [21:0] E_AND    = E_ADD | M_K_AND;
   localparam logic [21:0] E_NOT    = E_ADD | M_K_NOT;
   localparam logic [21:0] E_BRT    = M_LD_PC | M_PC_ADD | M_A2_OFF9;
   localparam logic [21:0] E_JMP    = M_LD_PC | M_PC_ADD | M_A1 | M_SR1;
   localparam logic [21:0] E_LDR1   = M_GMARMX | M_LD_MAR | M_A1 | M_A2_OFF6 | M_SR1;
   localparam logic [21:0] E_LDR3   = M_GMDR | M_LD_REG | M_LD_CC;
   localparam logic [21:0] E_STR2   = M_GALU | M_K_PASS | M_LD_MDR;
   localparam logic [21:0] E_STR3   = M_MREQ | M_MWE;

   function automatic logic [21:0] outs();
      return {bus.LD_MAR, bus.LD_MDR, bus.LD_IR, bus.LD_LOGIC, bus.LD_CC, bus.LD_REG,
              bus.LD_PC, bus.GatePC, bus.GateMDR, bus.GateALU, bus.GateMARMUX,
              bus.Mem_REQ, bus.Mem_WE, bus.SR1MUX, bus.DRMUX, bus.ADDR1MUX,
              bus.PCMUX, bus.ADDR2MUX, bus.ALUK};
   endfunction

   task automatic test_reset();
      Reset_n = 1'b0; bus.Run = 1'b0; bus.Continue = 1'b0; bus.IR = 16'h0000;
      bus.BEN = 1'b0; bus.Mem_RDY = 1'b0;
      #1;
      checks++;
      if (bus.State !== S_HALT || outs() !== E_HALT) begin
         failures++;
         $display("FAIL reset_held state=%0d outs=%h exp state=0 outs=0", bus.State, outs());
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (bus.State !== S_HALT || outs() !== E_HALT) begin
            failures++;
            $display("FAIL reset_idle[%0d] state=%0d outs=%h exp state=0 outs=0", i, bus.State, outs());
         end
         @(negedge Clk);
      end
   endtask

   task automatic test_add();
      logic [4:0]  st [7] = '{S_HALT, S_F1, S_F2, S_F3, S_DEC, S_ALU, S_F1};
      logic [21:0] ev [7] = '{E_HALT, E_F1, E_F2R, E_F3, E_DEC, E_ADD, E_F1};
      bus.IR = 16'h1042; bus.Mem_RDY = 1'b1;
      for (int i = 0; i < 7; i++) begin
         bus.Run = (i == 0);   // Run drops right after leaving HALTED
         #1;
         checks++;
         if (bus.State !== st[i]) begin
            failures++;
            $display("FAIL add_state[%0d] got=%0d exp=%0d", i, bus.State, st[i]);
         end
         checks++;
         if (outs() !== ev[i]) begin
            failures++;
            $display("FAIL add_ctrl[%0d] got=%h exp=%h", i, outs(), ev[i]);
         end
         @(negedge Clk);
      end
   endtask

   task automatic test_alu_jmp();
      logic [15:0] ir [15] = '{16'h5042, 16'h5042, 16'h5042, 16'h5042, 16'h5042,
                               16'h9042, 16'h9042, 16'h9042, 16'h9042, 16'h9042,
                               16'hC1C0, 16'hC1C0, 16'hC1C0, 16'hC1C0, 16'hC1C0};
      logic [4:0]  st [15] = '{S_F2, S_F3, S_DEC, S_ALU, S_F1, S_F2, S_F3, S_DEC, S_ALU, S_F1,
                               S_F2, S_F3, S_DEC, S_JMP, S_F1};
      logic [21:0] ev [15] = '{E_F2R, E_F3, E_DEC, E_AND, E_F1, E_F2R, E_F3, E_DEC, E_NOT, E_F1,
                               E_F2R, E_F3, E_DEC, E_JMP, E_F1};
      bus.Mem_RDY = 1'b1;
      for (int i = 0; i < 15; i++) begin
         bus.IR = ir[i];
         #1;
         checks++;
         if (bus.State !== st[i] || outs() !== ev[i]) begin
            failures++;
            $display("FAIL alu_jmp[%0d] state=%0d ctrl=%h exp state=%0d ctrl=%h",
                     i, bus.State, outs(), st[i], ev[i]);
         end
         @(negedge Clk);
      end
   endtask

   task automatic test_br_taken();
      logic        ben [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [4:0]  st [6]  = '{S_F2, S_F3, S_DEC, S_BR, S_BRT, S_F1};
      logic [21:0] ev [6]  = '{E_F2R, E_F3, E_DEC, E_HALT, E_BRT, E_F1};
      bus.IR = 16'h0A05; bus.Mem_RDY = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.BEN = ben[i];
         #1;
         checks++;
         if (bus.State !== st[i] || outs() !== ev[i]) begin
            failures++;
            $display("FAIL br_taken[%0d] state=%0d ctrl=%h exp state=%0d ctrl=%h",
                     i, bus.State, outs(), st[i], ev[i]);
         end
         @(negedge Clk);
      end
   endtask

   task automatic test_br_not_taken();
      // BEN high during DECODE but low in BR: only the BR-cycle value counts
      logic        ben [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [4:0]  st [5]  = '{S_F2, S_F3, S_DEC, S_BR, S_F1};
      logic [21:0] ev [5]  = '{E_F2R, E_F3, E_DEC, E_HALT, E_F1};
      bus.IR = 16'h0A05; bus.Mem_RDY = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.BEN = ben[i];
         #1;
         checks++;
         if (bus.State !== st[i] || outs() !== ev[i]) begin
            failures++;
            $display("FAIL br_not_taken[%0d] state=%0d ctrl=%h exp state=%0d ctrl=%h",
                     i, bus.State, outs(), st[i], ev[i]);
         end
         @(negedge Clk);
      end
   endtask

   task automatic test_ldr_wait();
      logic        rdy [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [4:0]  st [10]  = '{S_F2, S_F3, S_DEC, S_LDR1, S_LDR2, S_LDR2, S_LDR2, S_LDR2,
                                S_LDR3, S_F1};
      logic [21:0] ev [10]  = '{E_F2R, E_F3, E_DEC, E_LDR1, E_F2W, E_F2W, E_F2W, E_F2R,
                                E_LDR3, E_F1};
      bus.IR = 16'h6283; bus.BEN = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.Mem_RDY = rdy[i];
         #1;
         checks++;
         if (bus.State !== st[i] || outs() !== ev[i]) begin
            failures++;
            $display("FAIL ldr_wait[%0d] state=%0d ctrl=%h exp state=%0d ctrl=%h",
                     i, bus.State, outs(), st[i], ev[i]);
         end
         @(negedge Clk);
      end
   endtask

   task automatic test_str_wait();
      logic        rdy [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [4:0]  st [9]  = '{S_F2, S_F3, S_DEC, S_STR1, S_STR2, S_STR3, S_STR3, S_STR3, S_F1};
      logic [21:0] ev [9]  = '{E_F2R, E_F3, E_DEC, E_LDR1, E_STR2, E_STR3, E_STR3, E_STR3, E_F1};
      bus.IR = 16'h7283;
      for (int i = 0; i < 9; i++) begin
         bus.Mem_RDY = rdy[i];
         #1;
         checks++;
         if (bus.State !== st[i] || outs() !== ev[i]) begin
            failures++;
            $display("FAIL str_wait[%0d] state=%0d ctrl=%h exp state=%0d ctrl=%h",
                     i, bus.State, outs(), st[i], ev[i]);
         end
         @(negedge Clk);
      end
   endtask

   task automatic test_pause();
      logic        cnt [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [4:0]  st [11]  = '{S_F2, S_F3, S_DEC, S_P1, S_P1, S_P2, S_P2, S_P2, S_P2, S_P2, S_F1};
      logic [21:0] ev [11]  = '{E_F2R, E_F3, E_DEC, E_HALT, E_HALT, E_HALT, E_HALT, E_HALT,
                                E_HALT, E_HALT, E_F1};
      bus.IR = 16'hD000; bus.Mem_RDY = 1'b1;
      for (int i = 0; i < 11; i++) begin
         bus.Continue = cnt[i];
         #1;
         checks++;
         if (bus.State !== st[i] || outs() !== ev[i]) begin
            failures++;
            $display("FAIL pause[%0d] state=%0d ctrl=%h exp state=%0d ctrl=%h",
                     i, bus.State, outs(), st[i], ev[i]);
         end
         @(negedge Clk);
      end
   endtask

   task automatic test_reset_in_wait();
      logic [4:0]  st [6] = '{S_HALT, S_F1, S_F2, S_F3, S_DEC, S_F1};
      logic [21:0] ev [6] = '{E_HALT, E_F1, E_F2R, E_F3, E_DEC, E_F1};
      // previous test left the FSM entering F2; hold memory not ready
      bus.Mem_RDY = 1'b0; bus.IR = 16'hF025;
      #1;
      checks++;
      if (bus.State !== S_F2 || outs() !== E_F2W) begin
         failures++;
         $display("FAIL wait_before_reset state=%0d ctrl=%h exp state=%0d ctrl=%h",
                  bus.State, outs(), S_F2, E_F2W);
      end
      #1;
      Reset_n = 1'b0;
      #1;
      checks++;
      if (bus.State !== S_HALT || bus.Mem_REQ !== 1'b0 || outs() !== E_HALT) begin
         failures++;
         $display("FAIL reset_async state=%0d mem_req=%b ctrl=%h exp state=0 mem_req=0 ctrl=0",
                  bus.State, bus.Mem_REQ, outs());
      end
      @(negedge Clk);
      Reset_n = 1'b1; bus.Run = 1'b0; bus.Mem_RDY = 1'b1;
      @(negedge Clk);
      for (int i = 0; i < 6; i++) begin
         bus.Run = (i == 0);
         #1;
         checks++;
         if (bus.State !== st[i] || outs() !== ev[i]) begin
            failures++;
            $display("FAIL restart_nop[%0d] state=%0d ctrl=%h exp state=%0d ctrl=%h",
                     i, bus.State, outs(), st[i], ev[i]);
         end
         @(negedge Clk);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_alu_jmp();
      test_br_taken();
      test_br_not_taken();
      test_ldr_wait();
      test_str_wait();
      test_pause();
      test_reset_in_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
